// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC select (trap > stall > jump > branch > sequential),
// redirect alignment check and retired-fetch counter. Optional macro COMPRESSED_EN enables 2-byte steps.
module pc_next_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             jmp_en,
    input  logic [XLEN-1:0]  jmp_target,
    input  logic             trap_en,
    input  logic [XLEN-1:0]  trap_vector,
`ifdef COMPRESSED_EN
    input  logic             is_compressed,
`endif
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_step,
    output logic             misalign_err,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] instr_count
);

`ifdef COMPRESSED_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
    localparam bit              STEP_OK    = (STEP == 4) || (STEP == 2);
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
    localparam bit              STEP_OK    = (STEP == 4);
`endif

    if (!STEP_OK) begin : g_bad_step
        $error("pc_next_unit: unsupported STEP value");
    end

    logic [XLEN-1:0] pc_next;
    logic            advance;
    logic            err_set;
    logic [XLEN-1:0] err_addr;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) == '0;
    endfunction

`ifdef COMPRESSED_EN
    assign pc_plus_step = pc + (is_compressed ? XLEN'(2) : XLEN'(4));
`else
    assign pc_plus_step = pc + XLEN'(STEP);
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave a latch behind.
        pc_next  = pc_plus_step;
        advance  = 1'b1;
        err_set  = 1'b0;
        err_addr = '0;
        if (trap_en) begin
            pc_next = trap_vector & ~ALIGN_MASK;
            advance = 1'b0;
        end else if (stall) begin
            pc_next = pc;
            advance = 1'b0;
        end else if (jmp_en) begin
            if (is_aligned(jmp_target)) begin
                pc_next = jmp_target;
            end else begin
                err_set  = 1'b1;
                err_addr = jmp_target;
            end
        end else if (br_taken) begin
            if (is_aligned(br_target)) begin
                pc_next = br_target;
            end else begin
                err_set  = 1'b1;
                err_addr = br_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            pc            <= RESET_VEC;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
            instr_count   <= '0;
        end else begin
            pc           <= pc_next;
            misalign_err <= err_set;
            if (err_set) begin
                misalign_addr <= err_addr;
            end
            if (advance) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter stage: holds the PC register and computes the sequential next PC (PC + STEP) each cycle.
- Selects among sequential, branch, jump and trap redirects with fixed priority.
- Supports stall, checks redirect-target alignment and counts retired fetches.
- Sits at the front of the RISC-V datapath, feeding instruction memory address and the link value used by JAL/JALR writeback.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes. Must be 4, or 2 when COMPRESSED_EN is defined.
- CNT_W, 32, width of retired-fetch counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle; ignored by trap
- br_taken  in  1  conditional branch resolved taken
- br_target  in  XLEN  branch target address
- jmp_en  in  1  unconditional jump (JAL/JALR)
- jmp_target  in  XLEN  jump target address
- trap_en  in  1  trap/exception redirect request
- trap_vector  in  XLEN  trap handler address
- pc  out  XLEN  current PC (registered)
- pc_plus_step  out  XLEN  pc + STEP, combinational, modulo 2^XLEN (link value)
- misalign_err  out  1  one-cycle pulse: rejected misaligned redirect
- misalign_addr  out  XLEN  offending target, captured with misalign_err
- instr_count  out  CNT_W  count of cycles where PC advanced

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. On the rst edge: pc = RESET_VEC, misalign_err = 0, misalign_addr = 0, instr_count = 0. rst overrides all other inputs, including mid-stall and mid-redirect.
- Alignment mask A: low 2 bits; low 1 bit when COMPRESSED_EN is defined.
- Next-PC priority, evaluated each rising edge with rst = 0, highest first:
  1. trap_en: pc <= trap_vector with the A bits forced to 0. Applies even if stall = 1. instr_count unchanged.
  2. stall: pc holds. instr_count unchanged. Any br/jmp request in that cycle is discarded, not queued.
  3. jmp_en: if the target's A bits are zero, pc <= jmp_target. Otherwise pc <= pc_plus_step, misalign_err = 1, misalign_addr = jmp_target.
  4. br_taken: same rule as jmp_en, using br_target. If jmp_en and br_taken are both 1, jmp wins and the branch is ignored.
  5. Otherwise: pc <= pc_plus_step.
- misalign_err is high for exactly the cycle after the offending edge and clears on the next edge unless re-triggered. misalign_addr holds its value until the next error or reset.
- instr_count increments by 1 on every edge where rules 3–5 apply (including misaligned fallback). It wraps from 2^CNT_W−1 to 0.
- pc wraps 32'hFFFF_FFFC + 4 -> 0 with no flag.
- pc has 1-cycle latency from its select inputs. pc_plus_step has 0-cycle latency from pc.
- All state lives in a single clocked always block. Next-PC select is a separate combinational block.

Optional Feature:
- Macro COMPRESSED_EN.
- Defined: adds input is_compressed (1 bit). The sequential increment and pc_plus_step become pc + 2 when is_compressed = 1, else pc + 4. The alignment mask is bit 0 only, so 2-byte-aligned targets are legal. trap_vector forces bit 0 only.
- Not defined: no is_compressed port. Increment is fixed at STEP. 4-byte alignment is enforced.

Test Plan:
- rst = 1 for 2 cycles, RESET_VEC = 32'h0000_1000 -> pc = 32'h1000, instr_count = 0, misalign_err = 0. After 3 free cycles: pc = 32'h100C, instr_count = 3.
- stall = 1 for 2 cycles at pc = 32'h1008 with br_taken = 1, br_target = 32'h2000 -> pc stays 32'h1008 and the branch is dropped. stall = 0 -> pc = 32'h100C.
- jmp_en = 1, jmp_target = 32'h3000 and br_taken = 1, br_target = 32'h2000 in the same cycle -> pc = 32'h3000. Next cycle, pc_plus_step = 32'h3004.
- br_taken = 1, br_target = 32'h2002 at pc = 32'h1000 -> pc = 32'h1004, misalign_err pulses 1 cycle, misalign_addr = 32'h2002. With COMPRESSED_EN defined -> pc = 32'h2002, no error.
- trap_en = 1 with stall = 1 and jmp_en = 1, trap_vector = 32'h8000_0003 -> pc = 32'h8000_0000, instr_count unchanged.
- CNT_W = 4 with count at 15, one advance -> instr_count = 0. pc = 32'hFFFF_FFFC, one advance -> pc = 0. rst asserted during that cycle -> pc = RESET_VEC.
